// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for the S6 ALU register datapath: captures one command and
// replays it as ordered single-cycle load strobes on a shared data bus.
module alu_cmd_sequencer #(
  parameter int W          = 16,
  parameter int OP_W       = 2,
  parameter int GAP_CYCLES = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [W-1:0]    cmd_a,
  input  logic [W-1:0]    cmd_b,
  input  logic [OP_W-1:0] cmd_op,
  input  logic [3:0]      cmd_mask,
  output logic [W-1:0]    data_out,
  output logic            load_A,
  output logic            load_B,
  output logic            load_Op,
  output logic            updateRes,
  output logic            busy,
  output logic            done
);

  localparam int CW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [CW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;

  typedef enum logic [2:0] {
    IDLE,
    S_A,
    S_B,
    S_OP,
    S_UPD,
    GAP,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [3:0]      mask_q, mask_d;
  logic [CW-1:0]   gap_q, gap_d;
  logic [W-1:0]    data_q, data_d;
  logic [3:0]      cur_bit;
  logic [3:0]      rem;

  function automatic state_t first_step(input logic [3:0] m);
    if (m[0])      return S_A;
    else if (m[1]) return S_B;
    else if (m[2]) return S_OP;
    else if (m[3]) return S_UPD;
    else           return DONE;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      mask_q  <= '0;
      gap_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      mask_q  <= mask_d;
      gap_q   <= gap_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    mask_d  = mask_q;
    gap_d   = gap_q;
    data_d  = data_q;
    cur_bit = 4'b0000;
    rem     = mask_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          a_d     = cmd_a;
          b_d     = cmd_b;
          op_d    = cmd_op;
          mask_d  = cmd_mask;
          state_d = first_step(cmd_mask);
        end
      end
      S_A, S_B, S_OP, S_UPD: begin
        case (state_q)
          S_A:     cur_bit = 4'b0001;
          S_B:     cur_bit = 4'b0010;
          S_OP:    cur_bit = 4'b0100;
          default: cur_bit = 4'b1000;
        endcase
        // mask_q tracks the steps still pending; the lowest set bit is next
        rem    = mask_q & ~cur_bit;
        mask_d = rem;
        if (rem == 4'b0000) begin
          state_d = DONE;
        end else if (GAP_CYCLES > 0) begin
          state_d = GAP;
          gap_d   = GAP_LOAD;
        end else begin
          state_d = first_step(rem);
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = first_step(mask_q);
        else             gap_d   = gap_q - CW'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Bus value is registered alongside the state it belongs to
    case (state_d)
      S_A:     data_d = a_d;
      S_B:     data_d = b_d;
      S_OP:    data_d = W'(op_d);
      default: data_d = data_q;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    load_A    = (state_q == S_A);
    load_B    = (state_q == S_B);
    load_Op   = (state_q == S_OP);
    updateRes = (state_q == S_UPD);
    data_out  = data_q;
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: scoreboard of expected strobe events per command,
// a vector table of commands, and directed reset/back-to-back/zero-gap sequences.
module tb_alu_cmd_sequencer;

  localparam int W    = 16;
  localparam int OP_W = 2;
  localparam int G1   = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [W-1:0]    cmd_a, cmd_b;
  logic [OP_W-1:0] cmd_op;
  logic [3:0]      cmd_mask;

  logic            v1, rdy1, la1, lb1, lo1, lu1, busy1, done1;
  logic [W-1:0]    d1;
  logic            v0, rdy0, la0, lb0, lo0, lu0, busy0, done0;
  logic [W-1:0]    d0;

  alu_cmd_sequencer #(.W(W), .OP_W(OP_W), .GAP_CYCLES(G1)) dut1 (
    .clk(clk), .reset(rst_n), .cmd_valid(v1), .cmd_ready(rdy1),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_mask(cmd_mask),
    .data_out(d1), .load_A(la1), .load_B(lb1), .load_Op(lo1), .updateRes(lu1),
    .busy(busy1), .done(done1)
  );

  alu_cmd_sequencer #(.W(W), .OP_W(OP_W), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .reset(rst_n), .cmd_valid(v0), .cmd_ready(rdy0),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_mask(cmd_mask),
    .data_out(d0), .load_A(la0), .load_B(lb0), .load_Op(lo0), .updateRes(lu0),
    .busy(busy0), .done(done0)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int last_done_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  // sig = {done, updateRes, load_Op, load_B, load_A}
  typedef struct {
    int          cyc;
    logic [4:0]  sig;
    logic [W-1:0] data;
  } ev_t;

  ev_t          sb[$];
  logic [W-1:0] model_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected event stream for one command on the GAP_CYCLES=1 instance
  task automatic push_cmd(input int base, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [OP_W-1:0] op, input logic [3:0] mask);
    int         t;
    logic [3:0] rem;
    ev_t        e;
    t   = 1;
    rem = mask;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) begin
        case (i)
          0:       model_data = a;
          1:       model_data = b;
          2:       model_data = W'(op);
          default: model_data = model_data;
        endcase
        e.cyc  = base + t;
        e.sig  = 5'(1 << i);
        e.data = model_data;
        sb.push_back(e);
        rem[i] = 1'b0;
        t++;
        if (rem != 4'b0000) t += G1;
      end
    end
    e.cyc  = base + t;
    e.sig  = 5'b10000;
    e.data = model_data;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    logic [4:0] sig;
    ev_t        e;
    if (rst_n) begin
      sig = {done1, lu1, lo1, lb1, la1};
      check("onehot0_g1", 32'($onehot0(sig[3:0])), 32'd1);
      check("onehot0_g0", 32'($onehot0({lu0, lo0, lb0, la0})), 32'd1);
      while (sb.size() != 0 && sb[0].cyc < cyc) begin
        check("missed_event", 32'(sb[0].sig), 32'(sig));
        void'(sb.pop_front());
      end
      if (sig != 5'b0) begin
        if (sig[4]) last_done_cyc = cyc;
        if (sb.size() == 0) begin
          check("unexpected_strobe", 32'(sig), 32'd0);
        end else begin
          e = sb.pop_front();
          check("event_cycle", 32'(cyc), 32'(e.cyc));
          check("event_sig", 32'(sig), 32'(e.sig));
          check("event_data", 32'(d1), 32'(e.data));
          if (sig[4]) check("busy_in_done", 32'(busy1), 32'd1);
        end
      end
    end
  end

  task automatic send1(input logic [W-1:0] a, input logic [W-1:0] b, input logic [OP_W-1:0] op,
                       input logic [3:0] mask, input bit hold, output int base);
    int n;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_mask = mask;
    v1 = 1'b1;
    n  = 0;
    while (!rdy1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rdy1) begin
      check("accept_timeout", 32'd0, 32'd1);
      base = -1;
      v1 = 1'b0;
    end else begin
      base = cyc;
      push_cmd(base, a, b, op, mask);
      @(negedge clk);
      if (!hold) v1 = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || !rdy1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("idle_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic [OP_W-1:0] op;
    logic [3:0]      mask;
    int              exp_done;
  } vec_t;

  vec_t tbl[6];

  int           base, base2;
  logic [4:0]   exp0[1:6];
  logic [W-1:0] expd0[1:4];

  initial begin
    tbl[0] = '{16'h1234, 16'h00FF, 2'd2, 4'b1111, 8};
    tbl[1] = '{16'h1111, 16'h2222, 2'd3, 4'b0100, 2};
    tbl[2] = '{16'hDEAD, 16'hBEEF, 2'd1, 4'b0000, 1};
    tbl[3] = '{16'hA5A5, 16'h5A5A, 2'd0, 4'b0011, 4};
    tbl[4] = '{16'h0F0F, 16'hF0F0, 2'd2, 4'b1001, 4};
    tbl[5] = '{16'h7777, 16'h8888, 2'd1, 4'b1000, 2};

    rst_n = 1'b0; v1 = 1'b0; v0 = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_mask = '0;
    model_data = '0;
    #2;
    check("rst_ready", 32'(rdy1), 32'd1);
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_done", 32'(done1), 32'd0);
    check("rst_strobes", 32'({lu1, lo1, lb1, la1}), 32'd0);
    check("rst_data", 32'(d1), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      send1(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].mask, 1'b0, base);
      wait_idle();
      check($sformatf("done_cycle_%0d", i), 32'(last_done_cyc - base), 32'(tbl[i].exp_done));
      check($sformatf("ready_cycle_%0d", i), 32'(cyc - base), 32'(tbl[i].exp_done + 1));
    end

    // Held cmd_valid with changing inputs while busy; second accept at first IDLE edge
    send1(16'hAAAA, 16'hBBBB, 2'd1, 4'b0001, 1'b1, base);
    for (int n = 0; n < 20 && !rdy1; n++) begin
      cmd_a    = 16'($urandom);
      cmd_mask = 4'b1111;
      @(negedge clk);
    end
    send1(16'h5A5A, 16'h0001, 2'd0, 4'b0001, 1'b0, base2);
    check("b2b_accept_gap", 32'(base2 - base), 32'd3);
    wait_idle();

    // Zero-gap instance: strobes in consecutive cycles
    exp0[1] = 5'b00001; exp0[2] = 5'b00010; exp0[3] = 5'b00100;
    exp0[4] = 5'b01000; exp0[5] = 5'b10000; exp0[6] = 5'b00000;
    expd0[1] = 16'hC0DE; expd0[2] = 16'h0BAD; expd0[3] = 16'h0001; expd0[4] = 16'h0001;
    cmd_a = 16'hC0DE; cmd_b = 16'h0BAD; cmd_op = 2'd1; cmd_mask = 4'b1111;
    v0 = 1'b1;
    check("g0_ready", 32'(rdy0), 32'd1);
    @(negedge clk);
    v0 = 1'b0;
    for (int t = 1; t <= 6; t++) begin
      check($sformatf("g0_sig_c%0d", t), 32'({done0, lu0, lo0, lb0, la0}), 32'(exp0[t]));
      if (t <= 4) check($sformatf("g0_data_c%0d", t), 32'(d0), 32'(expd0[t]));
      if (t == 6) check("g0_ready_after", 32'(rdy0), 32'd1);
      @(negedge clk);
    end

    // Reset asserted during the gap after load_A aborts the command
    send1(16'h4321, 16'h8765, 2'd3, 4'b1111, 1'b0, base);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_strobes", 32'({lu1, lo1, lb1, la1}), 32'd0);
    check("abort_done", 32'(done1), 32'd0);
    check("abort_busy", 32'(busy1), 32'd0);
    check("abort_ready", 32'(rdy1), 32'd1);
    check("abort_data", 32'(d1), 32'd0);
    sb.delete();
    model_data = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("abort_idle_ready", 32'(rdy1), 32'd1);
    check("abort_idle_busy", 32'(busy1), 32'd0);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Sequencer that drives the load strobes and shared data bus of the S6 ALU register datapath (load_A, load_B, load_Op, updateRes, data_in).
- Accepts one complete command (operand A, operand B, opcode, step mask) through a valid/ready handshake.
- Replays the command as an ordered series of single-cycle strobes, with a programmable number of idle cycles between strobes.
- Sits between the user-input front end (switches/buttons or UART) and the ALU register block.

Parameters:
- W, 16, operand and data-bus width.
- OP_W, 2, opcode width; must be at most W.
- GAP_CYCLES, 1, idle cycles inserted after each strobe except the last (0 is legal).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_a  in  W  operand A.
- cmd_b  in  W  operand B.
- cmd_op  in  OP_W  opcode.
- cmd_mask  in  4  step enables: bit0 = A, bit1 = B, bit2 = Op, bit3 = Update.
- data_out  out  W  drives ALU data_in.
- load_A  out  1  one-cycle strobe.
- load_B  out  1  one-cycle strobe.
- load_Op  out  1  one-cycle strobe.
- updateRes  out  1  one-cycle strobe.
- busy  out  1  high from accept until the end of the DONE cycle.
- done  out  1  one-cycle pulse when the command completes.

Behaviour:
- States: IDLE, S_A, S_B, S_OP, S_UPD, GAP, DONE. All outputs are registered or decoded directly from registered state, so they are glitch-free.
- Reset (reset = 0, asynchronous): state = IDLE; data_out = 0; all strobes = 0; done = 0; busy = 0; cmd_ready = 1.
  - The captured command and the gap counter are cleared.
  - A reset mid-command aborts the command immediately; no further strobes are issued after release.
- cmd_ready = 1 only in IDLE.
- Accept occurs on a rising edge where cmd_valid && cmd_ready. On accept, cmd_a, cmd_b, cmd_op and cmd_mask are captured.
- Input changes while busy are ignored. cmd_valid held high while cmd_ready = 0 simply waits.
- Next state after accept: the first enabled step in the fixed order A, B, OP, UPD. If the mask is 0000, go directly to DONE; no strobes are issued.
- Step states (each lasts exactly one cycle):
  - S_A: load_A = 1, data_out = captured A.
  - S_B: load_B = 1, data_out = captured B.
  - S_OP: load_Op = 1, data_out = opcode zero-extended to W.
  - S_UPD: updateRes = 1, data_out holds its previous value.
- At most one strobe is high in any cycle.
- Latency: if accepted at edge k, the first strobe is high during cycle k+1.
- After each step:
  - If further enabled steps remain and GAP_CYCLES > 0, enter GAP for exactly GAP_CYCLES cycles. During GAP all strobes = 0 and data_out holds.
  - Otherwise go to the next enabled step, or to DONE after the last step. There is no gap after the last step.
  - Disabled steps are skipped and consume no cycles.
- DONE lasts one cycle: done = 1, busy = 1, then IDLE.
- data_out holds its last driven value in IDLE and DONE.
- Back-to-back commands: a new command may be accepted at the edge ending the first IDLE cycle after DONE.
- Gap counter: width is clog2(GAP_CYCLES+1) with a minimum of 1; it counts down and never wraps.
- With full mask and GAP_CYCLES = G, the span from accept to returning to IDLE is 4 + 3G + 1 cycles.

Test Plan:
- Reset, then full command A=16'h1234, B=16'h00FF, op=2'd2, mask=4'b1111, GAP_CYCLES=1. Accepted at edge 0, the bench must see:
  - cycle 1: load_A = 1, data_out = 16'h1234.
  - cycle 3: load_B = 1, data_out = 16'h00FF.
  - cycle 5: load_Op = 1, data_out = 16'h0002.
  - cycle 7: updateRes = 1.
  - cycle 8: done = 1.
  - cycle 9: cmd_ready = 1.
  - Cycles 2, 4 and 6 have no strobes.
- mask=4'b0100 with op=2'd3: load_Op high in cycle 1 with data_out = 16'h0003; done in cycle 2; no other strobes.
- mask=4'b0000: no strobes; done = 1 in cycle 1; cmd_ready = 1 in cycle 2.
- cmd_valid held high with changing cmd_a during a command: only the captured value appears. The second command is accepted exactly at the first IDLE edge.
- Assert reset = 0 while in GAP after load_A: all outputs go to reset values immediately. After release, no load_B or later strobes appear until a new accept.
- GAP_CYCLES=0 with full mask: strobes in consecutive cycles 1 through 4, done in cycle 5. A strobe $onehot0 check holds in every cycle.
